// File: rtl/reg_arb_pkg.sv
// Shared types and default sizes for the two-requester register write arbiter.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam int WIDTH  = 8;
    localparam int NREG   = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 8;

endpackage

// File: rtl/reg_write_arbiter_reg8.sv
// One bank register: loads data when ena is high and clears on asynchronous reset.
module reg8
    import reg_arb_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [W-1:0] data,
    output logic [W-1:0] r
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
        end else if (ena) begin
            r <= data;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter between two write requesters onto a small register bank,
// with a combinational read port, a wrapping write counter and a state debug output.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WIDTH  = reg_arb_pkg::WIDTH,
    parameter int NREG   = reg_arb_pkg::NREG,
    parameter int ADDR_W = reg_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WIDTH-1:0]  data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  data1,
    output logic              gnt1,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_count,
    output logic              fsm_state
);

    // Handshake: a requester keeps req/addr/data stable until it sees gnt=1 for
    // one cycle; the grant means the request has been latched. A req still high
    // at the edge after the write is treated as a fresh request.

    state_t              state, state_nx;
    logic                prio, prio_nx;
    logic [ADDR_W-1:0]   lat_addr, lat_addr_nx;
    logic [WIDTH-1:0]    lat_data, lat_data_nx;
    logic                gnt0_nx, gnt1_nx;
    logic [CNT_W-1:0]    cnt_nx;
    logic [NREG-1:0]     ena;
    logic [WIDTH-1:0]    regs [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            wr_count <= '0;
        end else begin
            state    <= state_nx;
            prio     <= prio_nx;
            lat_addr <= lat_addr_nx;
            lat_data <= lat_data_nx;
            gnt0     <= gnt0_nx;
            gnt1     <= gnt1_nx;
            wr_count <= cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        prio_nx     = prio;
        lat_addr_nx = lat_addr;
        lat_data_nx = lat_data;
        gnt0_nx     = 1'b0;
        gnt1_nx     = 1'b0;
        cnt_nx      = wr_count;
        ena         = '0;
        case (state)
            IDLE: begin
                // prio=0 favours requester 0 on contention; the loser gets priority next.
                if (req0 && (!req1 || !prio)) begin
                    lat_addr_nx = addr0;
                    lat_data_nx = data0;
                    gnt0_nx     = 1'b1;
                    prio_nx     = 1'b1;
                    state_nx    = WRITE;
                end else if (req1) begin
                    lat_addr_nx = addr1;
                    lat_data_nx = data1;
                    gnt1_nx     = 1'b1;
                    prio_nx     = 1'b0;
                    state_nx    = WRITE;
                end
            end
            WRITE: begin
                ena[lat_addr] = 1'b1;
                cnt_nx        = wr_count + CNT_W'(1);
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            reg8 #(.W(WIDTH)) u_reg (
                .clk  (clk),
                .rst  (rst),
                .ena  (ena[gi]),
                .data (lat_data),
                .r    (regs[gi])
            );
        end
    endgenerate

    assign rd_data   = regs[rd_addr];
    assign busy      = (state == WRITE);
    assign fsm_state = state;

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares a small bank of 8-bit enable-gated registers between two write requesters, using round-robin arbitration and a one-cycle grant handshake. A two-state controller latches the winning request, then drives exactly one register enable for one cycle. A combinational read port and a wrapping write counter are exposed for the core datapath and debug. The block sits between pipeline-side producers (e.g. writeback and CSR/debug paths) and the register bank.

## Interface
- WIDTH, 8, register data width
- NREG, 4, number of registers in the bank
- ADDR_W, 2, address width; NREG = 2**ADDR_W
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- req0  input  1  requester 0 write request
- addr0  input  ADDR_W  requester 0 target register
- data0  input  WIDTH  requester 0 write data
- gnt0  output  1  requester 0 grant, one-cycle pulse
- req1, addr1, data1, gnt1: same as above, for requester 1
- rd_addr  input  ADDR_W  read-port address
- rd_data  output  WIDTH  contents of register rd_addr (combinational)
- busy  output  1  high while in state WRITE
- wr_count  output  8  number of completed writes, wraps 255→0

## Operation
- States: IDLE, WRITE. Reset state is IDLE.
- IDLE, no request: stay in IDLE; all outputs hold.
- IDLE, one request: grant it.
- IDLE, both requests: grant the requester selected by `prio` (0 selects req0, 1 selects req1).
- On a grant:
  - Latch the winner's addr and data into lat_addr and lat_data.
  - Set the winner's gnt to 1 and go to WRITE.
  - Set `prio` to the loser's index.
- WRITE:
  - Assert the enable of register lat_addr for exactly this cycle. The register loads lat_data at the next edge.
  - Clear gnt, increment wr_count, return to IDLE.
  - Requests are ignored in this state.
- Handshake:
  - A requester holds req, addr and data stable until it samples gnt=1.
  - It may deassert req in the cycle gnt is high.
  - If req is still high at the IDLE edge after the write, that is a new request.
- rd_data = reg[rd_addr]. A read of the register being written returns the old value until the write edge.
- Reset, including reset asserted mid-WRITE:
  - All registers clear to 0.
  - gnt0, gnt1 and busy go to 0, wr_count goes to 0, `prio` goes to 0, state goes to IDLE.
  - A pending latched write is discarded.
- Reset values of outputs: gnt0=0, gnt1=0, busy=0, wr_count=0, rd_data=0.

## Timing
- Request sampled at edge N (in IDLE) → gnt and busy high from edge N to edge N+1.
- The register updates at edge N+1 and is visible on rd_data after edge N+1.
- Maximum throughput is one write per 2 cycles. The earliest next grant is at edge N+2.
- Under continuous contention, grants alternate 0,1,0,1 starting with requester 0 after reset.
- gnt0 and gnt1 are never high in the same cycle.
- wr_count increments at the WRITE-exit edge (N+1).

## Structure
- Shared package reg_arb_pkg holds:
  - the state enumeration (IDLE=1'b0, WRITE=1'b1);
  - default WIDTH, NREG, ADDR_W;
  - wr_count width (8).
- Sub-module reg8 is instantiated NREG times via generate. Its ports are clk, rst, ena, data and r, with an 8-bit enable-gated load and clear on reset.
- The arbiter FSM, latches, `prio` and counter live in reg_write_arbiter.

## Test plan
- Reset: drive rst=0 mid-run → all regs, rd_data, wr_count and gnt read 0 immediately, without waiting for a clock edge.
- Single write: req0=1, addr0=2, data0=8'hA5 → gnt0 pulses one cycle; after the next edge rd_addr=2 gives 8'hA5, wr_count=1, other regs stay 0.
- Contention: req0 and req1 held high with addr0=1/data0=8'h11 and addr1=3/data1=8'h33, for 8 cycles → grants in order 0,1,0,1; reg1=8'h11, reg3=8'h33, wr_count=4.
- Same address: both requesters target addr 0 with 8'h0F (req0) and 8'hF0 (req1) → after two writes reg0=8'hF0, because requester 0 wins first.
- Reset mid-WRITE: assert rst low while busy=1 with data 8'h77 latched → target register stays 0, gnt=0, state IDLE; after release, req1 wins first only if req0 is low (`prio` is back to 0).
- Counter wrap: issue 256 single writes → wr_count returns to 0; the final data value is visible on rd_data.
